// File: rtl/mult_fu.sv
// Pipelined integer multiply unit between the RS mult issue port and the CDB arbiter.
// Builds the 64-bit product one multiplier chunk per stage and honours branch squash/clear.
package mult_fu_pkg;
    localparam int PHYS_REG_IDX_W = 6;
    localparam int BR_MASK_W      = 4;

    typedef logic [PHYS_REG_IDX_W-1:0] PHYS_REG_IDX;
    typedef logic [BR_MASK_W-1:0]      BR_MASK;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        SQUASH  = 2'd1,
        CLEAR   = 2'd2
    } BR_TASK;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } MULT_FUNC;

    typedef struct packed {
        PHYS_REG_IDX reg_idx;
        logic        ready;
    } PHYS_REG_TAG;

    typedef struct packed {
        logic [31:0] pc;
        PHYS_REG_TAG t;
        BR_MASK      b_mask;
    } RS_PACKET;
endpackage

module mult_fu
    import mult_fu_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int XLEN   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  RS_PACKET          in_packet,
    input  logic [1:0]        mult_func,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  BR_MASK            rem_b_id,
    input  BR_TASK            br_task,
    input  logic              cdb_gnt,
    output logic              busy,
    output logic              out_valid,
    output PHYS_REG_IDX       out_preg,
    output logic [XLEN-1:0]   out_result,
    output RS_PACKET          out_packet
);
    localparam int PW   = 2 * XLEN;
    localparam int C    = PW / STAGES;
    localparam int LAST = STAGES - 1;

    function automatic logic squashHit(input BR_TASK bt, input BR_MASK m, input BR_MASK id);
        return (bt == SQUASH) && (|(m & id));
    endfunction

    function automatic BR_MASK clearMask(input BR_TASK bt, input BR_MASK m, input BR_MASK id);
        return (bt == CLEAR) ? (m ^ (m & id)) : m;
    endfunction

    logic [STAGES-1:0] stageValid_q, stageValid_d;
    RS_PACKET          stagePacket_q [STAGES];
    RS_PACKET          stagePacket_d [STAGES];
    logic [1:0]        stageFunc_q   [STAGES];
    logic [1:0]        stageFunc_d   [STAGES];
    logic [PW-1:0]     stageMcand_q  [STAGES];
    logic [PW-1:0]     stageMcand_d  [STAGES];
    logic [PW-1:0]     stageMplier_q [STAGES];
    logic [PW-1:0]     stageMplier_d [STAGES];
    logic [PW-1:0]     stageAcc_q    [STAGES];
    logic [PW-1:0]     stageAcc_d    [STAGES];

    logic [STAGES-1:0] srcValid;
    RS_PACKET          srcPacket [STAGES];
    logic [1:0]        srcFunc   [STAGES];
    logic [PW-1:0]     srcMcand  [STAGES];
    logic [PW-1:0]     srcMplier [STAGES];
    logic [PW-1:0]     srcAcc    [STAGES];

    logic          stall;
    logic          accept;
    logic          rs1Signed, rs2Signed;
    logic [PW-1:0] mcandExt, mplierExt;

    assign stall     = stageValid_q[LAST] && !cdb_gnt;
    assign busy      = stall;
    assign accept    = in_valid && !stall;
    assign rs1Signed = (mult_func == MULH) || (mult_func == MULHSU);
    assign rs2Signed = (mult_func == MULH);
    assign mcandExt  = {{(PW-XLEN){rs1Signed & rs1_val[XLEN-1]}}, rs1_val};
    assign mplierExt = {{(PW-XLEN){rs2Signed & rs2_val[XLEN-1]}}, rs2_val};

    // Stage 0 is fed by the issue port with an empty accumulator; later stages by their predecessor.
    always_comb begin
        srcValid[0]  = accept;
        srcPacket[0] = in_packet;
        srcFunc[0]   = mult_func;
        srcMcand[0]  = mcandExt;
        srcMplier[0] = mplierExt;
        srcAcc[0]    = '0;
        for (int s = 1; s < STAGES; s++) begin
            srcValid[s]  = stageValid_q[s-1];
            srcPacket[s] = stagePacket_q[s-1];
            srcFunc[s]   = stageFunc_q[s-1];
            srcMcand[s]  = stageMcand_q[s-1];
            srcMplier[s] = stageMplier_q[s-1];
            srcAcc[s]    = stageAcc_q[s-1];
        end
    end

    // A stalled pipe holds every stage, but squash and clear still act on the held entries.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            stageValid_d[s]  = stageValid_q[s];
            stagePacket_d[s] = stagePacket_q[s];
            stageFunc_d[s]   = stageFunc_q[s];
            stageMcand_d[s]  = stageMcand_q[s];
            stageMplier_d[s] = stageMplier_q[s];
            stageAcc_d[s]    = stageAcc_q[s];
            if (stall) begin
                stageValid_d[s] = stageValid_q[s] &&
                                  !squashHit(br_task, stagePacket_q[s].b_mask, rem_b_id);
                stagePacket_d[s].b_mask = clearMask(br_task, stagePacket_q[s].b_mask, rem_b_id);
            end else begin
                stageValid_d[s] = srcValid[s] &&
                                  !squashHit(br_task, srcPacket[s].b_mask, rem_b_id);
                if (srcValid[s]) begin
                    stagePacket_d[s]        = srcPacket[s];
                    stagePacket_d[s].b_mask = clearMask(br_task, srcPacket[s].b_mask, rem_b_id);
                    stageFunc_d[s]          = srcFunc[s];
                    stageMcand_d[s]         = srcMcand[s];
                    stageMplier_d[s]        = srcMplier[s] >> C;
                    stageAcc_d[s]           = srcAcc[s] +
                        ((srcMcand[s] * PW'(srcMplier[s][C-1:0])) << (s * C));
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stageValid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                stagePacket_q[s] <= '0;
                stageFunc_q[s]   <= '0;
                stageMcand_q[s]  <= '0;
                stageMplier_q[s] <= '0;
                stageAcc_q[s]    <= '0;
            end
        end else begin
            stageValid_q <= stageValid_d;
            for (int s = 0; s < STAGES; s++) begin
                stagePacket_q[s] <= stagePacket_d[s];
                stageFunc_q[s]   <= stageFunc_d[s];
                stageMcand_q[s]  <= stageMcand_d[s];
                stageMplier_q[s] <= stageMplier_d[s];
                stageAcc_q[s]    <= stageAcc_d[s];
            end
        end
    end

    // A result being squashed this cycle must never be offered to the arbiter.
    assign out_valid  = stageValid_q[LAST] &&
                        !squashHit(br_task, stagePacket_q[LAST].b_mask, rem_b_id);
    assign out_packet = stagePacket_q[LAST];
    assign out_preg   = stagePacket_q[LAST].t.reg_idx;
    assign out_result = (stageFunc_q[LAST] == MUL) ? stageAcc_q[LAST][XLEN-1:0]
                                                   : stageAcc_q[LAST][PW-1:XLEN];

    always_ff @(posedge clock) begin
        if (!reset && in_valid) begin
            assert (!busy);
        end
    end
endmodule

// File: tb/tb_mult_fu.sv
// Directed bench for mult_fu: latency, function variants, stall, squash/clear and reset.
// Expected values are hand-computed constants.
module tb_mult_fu;
    import mult_fu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    RS_PACKET    in_packet;
    logic [1:0]  mult_func;
    logic [31:0] rs1_val, rs2_val;
    BR_MASK      rem_b_id;
    BR_TASK      br_task;
    logic        cdb_gnt;
    logic        busy;
    logic        out_valid;
    PHYS_REG_IDX out_preg;
    logic [31:0] out_result;
    RS_PACKET    out_packet;

    int errors = 0;
    int checks = 0;

    logic [1:0]  opFunc [4];
    logic [31:0] opA    [4];
    logic [31:0] opB    [4];
    logic [31:0] opExp  [4];

    mult_fu #(.STAGES(4), .XLEN(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_packet  (in_packet),
        .mult_func  (mult_func),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .rem_b_id   (rem_b_id),
        .br_task    (br_task),
        .cdb_gnt    (cdb_gnt),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_preg   (out_preg),
        .out_result (out_result),
        .out_packet (out_packet)
    );

    always #5 clock = ~clock;

    function automatic RS_PACKET mkPkt(input int preg, input BR_MASK m);
        RS_PACKET p;
        p           = '0;
        p.pc        = 32'h1000 + 32'(preg * 4);
        p.t.reg_idx = PHYS_REG_IDX'(preg);
        p.b_mask    = m;
        return p;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input RS_PACKET p, input logic g,
                                 input BR_TASK bt, input BR_MASK rb);
        in_valid  = v;
        mult_func = f;
        rs1_val   = a;
        rs2_val   = b;
        in_packet = p;
        cdb_gnt   = g;
        br_task   = bt;
        rem_b_id  = rb;
        #1;
    endtask

    task automatic idle(input logic g);
        applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, '0, g, BR_NONE, 4'b0000);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle(1'b1);
        tick();
        tick();
        reset = 1'b0;
        idle(1'b1);
        checkOutput("rst_valid",  64'(out_valid),  64'd0);
        checkOutput("rst_busy",   64'(busy),       64'd0);
        checkOutput("rst_result", 64'(out_result), 64'd0);
        checkOutput("rst_preg",   64'(out_preg),   64'd0);
        checkOutput("rst_packet", 64'(out_packet), 64'd0);

        // Single MUL: issue in cycle 0, result in cycle 4
        applyStimulus(1'b1, MUL, 32'd7, 32'd6, mkPkt(5, 4'b0000), 1'b1, BR_NONE, 4'b0000);
        checkOutput("mul_busy_issue", 64'(busy), 64'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            idle(1'b1);
            checkOutput("mul_wait_valid", 64'(out_valid), 64'd0);
            checkOutput("mul_wait_busy",  64'(busy),      64'd0);
        end
        tick();
        idle(1'b1);
        checkOutput("mul_valid",  64'(out_valid),  64'd1);
        checkOutput("mul_result", 64'(out_result), 64'd42);
        checkOutput("mul_preg",   64'(out_preg),   64'd5);
        tick();
        idle(1'b1);
        checkOutput("mul_after_valid", 64'(out_valid), 64'd0);

        // Back-to-back variants
        opFunc[0] = MULH;   opA[0] = 32'hFFFFFFFF; opB[0] = 32'hFFFFFFFF; opExp[0] = 32'h00000000;
        opFunc[1] = MULHU;  opA[1] = 32'hFFFFFFFF; opB[1] = 32'hFFFFFFFF; opExp[1] = 32'hFFFFFFFE;
        opFunc[2] = MULHSU; opA[2] = 32'hFFFFFFFF; opB[2] = 32'h00000002; opExp[2] = 32'hFFFFFFFF;
        opFunc[3] = MUL;    opA[3] = 32'h12345678; opB[3] = 32'h00000010; opExp[3] = 32'h23456780;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, opFunc[i], opA[i], opB[i], mkPkt(i + 1, 4'b0000), 1'b1, BR_NONE, 4'b0000);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            checkOutput("b2b_valid",  64'(out_valid),  64'd1);
            checkOutput("b2b_busy",   64'(busy),       64'd0);
            checkOutput("b2b_result", 64'(out_result), 64'(opExp[i]));
            checkOutput("b2b_preg",   64'(out_preg),   64'(i + 1));
            tick();
        end
        idle(1'b1);
        checkOutput("b2b_after_valid", 64'(out_valid), 64'd0);
        tick();

        // Full pipeline with cdb_gnt low in cycles 4-6
        opFunc[0] = MUL;   opA[0] = 32'd3;        opB[0] = 32'd5;        opExp[0] = 32'd15;
        opFunc[1] = MUL;   opA[1] = 32'd100;      opB[1] = 32'd200;      opExp[1] = 32'd20000;
        opFunc[2] = MULHU; opA[2] = 32'h80000000; opB[2] = 32'd4;        opExp[2] = 32'd2;
        opFunc[3] = MUL;   opA[3] = 32'hFFFFFFFF; opB[3] = 32'hFFFFFFFF; opExp[3] = 32'd1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, opFunc[i], opA[i], opB[i], mkPkt(i + 20, 4'b0000), 1'b1, BR_NONE, 4'b0000);
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            idle(1'b0);
            checkOutput("stall_valid",  64'(out_valid),  64'd1);
            checkOutput("stall_busy",   64'(busy),       64'd1);
            checkOutput("stall_result", 64'(out_result), 64'(opExp[0]));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            checkOutput("drain_valid",  64'(out_valid),  64'd1);
            checkOutput("drain_busy",   64'(busy),       64'd0);
            checkOutput("drain_result", 64'(out_result), 64'(opExp[i]));
            checkOutput("drain_preg",   64'(out_preg),   64'(i + 20));
            tick();
        end
        idle(1'b1);
        checkOutput("drain_after_valid", 64'(out_valid), 64'd0);
        tick();

        // Squash one in-flight op, then clear the other's branch bit
        applyStimulus(1'b1, MUL, 32'd9, 32'd9, mkPkt(7, 4'b0010), 1'b1, BR_NONE, 4'b0000);
        tick();
        applyStimulus(1'b1, MUL, 32'd2, 32'd2, mkPkt(8, 4'b0001), 1'b1, BR_NONE, 4'b0000);
        tick();
        applyStimulus(1'b0, MUL, 32'd0, 32'd0, '0, 1'b1, SQUASH, 4'b0001);
        tick();
        applyStimulus(1'b0, MUL, 32'd0, 32'd0, '0, 1'b1, CLEAR, 4'b0010);
        tick();
        idle(1'b1);
        checkOutput("sq_valid",  64'(out_valid),  64'd1);
        checkOutput("sq_result", 64'(out_result), 64'd81);
        checkOutput("sq_preg",   64'(out_preg),   64'd7);
        checkOutput("clr_packet", 64'(out_packet), 64'(mkPkt(7, 4'b0000)));
        for (int i = 0; i < 2; i++) begin
            tick();
            idle(1'b1);
            checkOutput("sq_dropped_valid", 64'(out_valid), 64'd0);
        end
        tick();

        // Squash of a stalled last stage
        applyStimulus(1'b1, MUL, 32'd5, 32'd5, mkPkt(10, 4'b0100), 1'b1, BR_NONE, 4'b0000);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            tick();
        end
        idle(1'b0);
        checkOutput("sqst_pre_valid", 64'(out_valid), 64'd1);
        checkOutput("sqst_pre_busy",  64'(busy),      64'd1);
        tick();
        applyStimulus(1'b0, MUL, 32'd0, 32'd0, '0, 1'b0, SQUASH, 4'b0100);
        checkOutput("sqst_valid", 64'(out_valid), 64'd0);
        checkOutput("sqst_busy",  64'(busy),      64'd1);
        tick();
        idle(1'b0);
        checkOutput("sqst_after_valid", 64'(out_valid), 64'd0);
        checkOutput("sqst_after_busy",  64'(busy),      64'd0);
        tick();

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, MUL, 32'd3 + 32'(i), 32'd7, mkPkt(11 + i, 4'b0000), 1'b1, BR_NONE, 4'b0000);
            tick();
        end
        reset = 1'b1;
        idle(1'b0);
        tick();
        reset = 1'b0;
        idle(1'b1);
        checkOutput("rst2_valid",  64'(out_valid),  64'd0);
        checkOutput("rst2_busy",   64'(busy),       64'd0);
        checkOutput("rst2_result", 64'(out_result), 64'd0);
        checkOutput("rst2_preg",   64'(out_preg),   64'd0);
        checkOutput("rst2_packet", 64'(out_packet), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            idle(1'b1);
            checkOutput("rst2_no_result", 64'(out_valid), 64'd0);
        end

        // Fresh issue after reset
        applyStimulus(1'b1, MUL, 32'd11, 32'd13, mkPkt(9, 4'b0000), 1'b1, BR_NONE, 4'b0000);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            tick();
        end
        idle(1'b1);
        checkOutput("post_rst_valid",  64'(out_valid),  64'd1);
        checkOutput("post_rst_result", 64'(out_result), 64'd143);
        checkOutput("post_rst_preg",   64'(out_preg),   64'd9);
        tick();
        idle(1'b1);
        checkOutput("post_rst_after_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_fu.md
# mult_fu

Pipelined integer multiply functional unit directly downstream of the reservation station's mult issue port. It accepts one issued RS_PACKET per cycle with its two source operand values, computes the 64-bit product over `STAGES` pipeline stages, and presents the selected 32-bit result plus destination physical register to the CDB arbiter. It drives the per-unit bit of `fu_mult_busy` back to the RS and obeys branch squash/clear for early branch recovery.

## Interface
Parameters:
- STAGES, 4, pipeline depth; must divide 64; each stage consumes 64/STAGES multiplier bits
- XLEN, 32, operand/result width

Ports:
- clock  input  1  clock
- reset  input  1  synchronous, active-high
- in_valid  input  1  issue valid from RS
- in_packet  input  RS_PACKET  issued entry; carries dest tag `t`, `b_mask`, decoded values
- mult_func  input  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU
- rs1_val, rs2_val  input  XLEN  operand values
- rem_b_id  input  BR_MASK  resolving branch bit
- br_task  input  BR_TASK  SQUASH / CLEAR / other
- cdb_gnt  input  1  arbiter accepts output this cycle
- busy  output  1  unit cannot accept an issue this cycle
- out_valid  output  1  result pending for CDB
- out_preg  output  PHYS_REG_IDX width  destination = packet `t.reg_idx`
- out_result  output  XLEN  selected product half
- out_packet  output  RS_PACKET  packet of the output stage (b_mask updated)

## Operation
- Operand extension to 64 bits at entry: rs1 signed for MULH/MULHSU else zero-extend; rs2 signed for MULH only.
- Stage registers per stage s: valid, packet, func, multiplicand (64b), multiplier (64b, shifted right by chunk each stage), accumulator (64b).
- Stage 0 captures input and adds (mcand × chunk0); stage s adds (mcand << s·C) × chunk_s, C = 64/STAGES. Accumulation is mod 2^64; after the final stage, acc = exact low 64 bits of the extended product.
- Result: MUL → acc[31:0]; MULH/MULHSU/MULHU → acc[63:32].
- Stall: stall = last-stage valid && !cdb_gnt. Under stall every stage holds; busy = stall. Without stall all stages advance; the last stage is vacated when granted.
- Input is accepted iff in_valid && !busy; issuing while busy is a protocol error (ignored, assertion fires).
- SQUASH: any stage (and the accepting input) with b_mask & rem_b_id ≠ 0 becomes invalid at the edge; out_valid is combinationally forced 0 that same cycle for a matching last stage, so a squashed result is never granted.
- CLEAR: matching b_mask bit XOR-cleared in every valid stage and in the incoming packet; execution unaffected.
- Squash and stall same cycle: squash wins for matching stages; non-matching stages still hold.

## Timing
- Reset: all stage valid = 0; busy = 0, out_valid = 0, out_result = 0, out_preg = 0, out_packet = 0 the cycle after reset is sampled; in-flight work is discarded.
- Latency: issued in cycle N (accepted at end of N) → out_valid in cycle N+STAGES with no stall.
- Throughput: one accepted op per cycle when not stalled.
- busy and out_valid are combinational from stage state, cdb_gnt, br_task, rem_b_id; outputs otherwise from the last stage register.
- Pipeline full + stalled: busy = 1 until the grant cycle; accepting resumes in that same grant cycle.

## Test plan
- MUL 7×6, issue cycle 0, cdb_gnt=1 → out_valid cycle 4, out_result=42, out_preg = issued t.reg_idx; busy never asserted.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000; MULHU same operands → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- Four back-to-back issues cycles 0–3 → results cycles 4–7 in issue order with correct values.
- Full pipeline, cdb_gnt low cycles 4–6 → busy=1 cycles 4–6, first result held stable, all four results delivered cycles 7–10 without loss or duplication.
- Ops with b_mask 0001 (stage 1) and 0010 (stage 2); SQUASH rem_b_id=0001 → only first dropped, second completes; then CLEAR 0010 → out_packet.b_mask=0000. Squash of stalled last stage → out_valid=0 that cycle, never granted.
- Reset asserted with three ops in flight → next cycle all outputs 0, no result ever emerges; new issue after reset completes normally.
